// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one 64-bit ALU between NUM_REQ issue ports, result in a one-entry valid/ready register
//   clk_i, rst_i (sync, active-high); req_valid_i/req_ready_o handshake per requester;
//   req_rs1_i, req_rs2_i, req_instr_type_i, req_tag_i payload per requester;
//   res_valid_o/res_ready_i result handshake with res_data_o, res_tag_o, res_src_o.
//   Optional `define ALU_ISSUE_ARB_PERF_EN adds perf_grant_cnt_o, perf_stall_cnt_o, perf_conflict_cnt_o.
//   instr_type encoding: 0 ADD 1 SUB 2 XOR 3 OR 4 AND 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//   10 ADDW 11 SUBW 12 SLLW 13 SRLW 14 SRAW, 15 unsupported (result 0).
module alu_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 6,
    parameter int RR_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][63:0]        req_rs1_i,
    input  logic [NUM_REQ-1:0][63:0]        req_rs2_i,
    input  logic [NUM_REQ-1:0][3:0]         req_instr_type_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [63:0]                     res_data_o,
    output logic [TAG_W-1:0]                res_tag_o,
    output logic [RR_W-1:0]                 res_src_o
`ifdef ALU_ISSUE_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]        perf_grant_cnt_o,
    output logic [31:0]                     perf_stall_cnt_o,
    output logic [31:0]                     perf_conflict_cnt_o
`endif
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR = 4'd3,
                           OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_ADDW = 4'd10, OP_SUBW = 4'd11,
                           OP_SLLW = 4'd12, OP_SRLW = 4'd13, OP_SRAW = 4'd14;

    function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        logic [31:0] w;
        logic [63:0] r;
        case (op)
            OP_ADDW: w = a[31:0] + b[31:0];
            OP_SUBW: w = a[31:0] - b[31:0];
            OP_SLLW: w = a[31:0] << b[4:0];
            OP_SRLW: w = a[31:0] >> b[4:0];
            OP_SRAW: w = 32'($signed(a[31:0]) >>> b[4:0]);
            default: w = '0;
        endcase
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLL:  r = a << b[5:0];
            OP_SRL:  r = a >> b[5:0];
            OP_SRA:  r = 64'($signed(a) >>> b[5:0]);
            OP_SLT:  r = {63'd0, $signed(a) < $signed(b)};
            OP_SLTU: r = {63'd0, a < b};
            OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW: r = {{32{w[31]}}, w};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [RR_W-1:0] rr_q;
    logic [RR_W-1:0] win;
    logic [RR_W-1:0] idx;
    logic            can_accept;
    logic            xfer;

    assign can_accept = ~res_valid_o | res_ready_i;

    // Scan downward so the requester closest to rr_q is the last to overwrite win.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = RR_W'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid_i[idx]) win = idx;
        end
    end

    assign req_ready_o = (|req_valid_i && can_accept && !rst_i) ? NUM_REQ'(1) << win : '0;
    assign xfer        = |req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o <= 1'b0;
            rr_q        <= '0;
            res_data_o  <= '0;
            res_tag_o   <= '0;
            res_src_o   <= '0;
        end else if (xfer) begin
            res_valid_o <= 1'b1;
            res_data_o  <= alu(req_rs1_i[win], req_rs2_i[win], req_instr_type_i[win]);
            res_tag_o   <= req_tag_i[win];
            res_src_o   <= win;
            rr_q        <= (win == RR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return &c ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_grant_cnt_o    <= '0;
            perf_stall_cnt_o    <= '0;
            perf_conflict_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (xfer && win == RR_W'(i)) perf_grant_cnt_o[i] <= sat_inc(perf_grant_cnt_o[i]);
            if (res_valid_o && !res_ready_i) perf_stall_cnt_o <= sat_inc(perf_stall_cnt_o);
            if ($countones(req_valid_i) > 1 && can_accept) perf_conflict_cnt_o <= sat_inc(perf_conflict_cnt_o);
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: randomized scoreboard bench for alu_issue_arbiter (NUM_REQ=2, TAG_W=6)
module tb_alu_issue_arbiter;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0][63:0]  rs1 = '0;
    logic [1:0][63:0]  rs2 = '0;
    logic [1:0][3:0]   op = '0;
    logic [1:0][5:0]   tag = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [63:0]       res_data;
    logic [5:0]        res_tag;
    logic              res_src;
`ifdef ALU_ISSUE_ARB_PERF_EN
    logic [1:0][31:0]  perf_grant;
    logic [31:0]       perf_stall;
    logic [31:0]       perf_conflict;
    int                m_grant[2];
    int                m_stall = 0;
    int                m_conflict = 0;
`endif

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NUM_REQ(2), .TAG_W(6)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_rs1_i(rs1), .req_rs2_i(rs2), .req_instr_type_i(op), .req_tag_i(tag),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_tag_o(res_tag), .res_src_o(res_src)
`ifdef ALU_ISSUE_ARB_PERF_EN
        , .perf_grant_cnt_o(perf_grant), .perf_stall_cnt_o(perf_stall), .perf_conflict_cnt_o(perf_conflict)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic [5:0]  t;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   m_rr = 0;
    bit   m_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] x);
        return 64'(longint'(int'(x[31:0])));
    endfunction

    // Reference ALU from the instruction semantics, using longint arithmetic.
    function automatic logic [63:0] model_alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] o);
        longint sa = longint'(a);
        longint sb = longint'(b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 64'd1;
            4'd2:  return a ^ b;
            4'd3:  return a | b;
            4'd4:  return a & b;
            4'd5:  return a * (64'd1 << b[5:0]);
            4'd6:  return a >> b[5:0];
            4'd7:  return 64'(sa >>> b[5:0]);
            4'd8:  return (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  return (a < b) ? 64'd1 : 64'd0;
            4'd10: return sext32(a + b);
            4'd11: return sext32(a - b);
            4'd12: return sext32(a * (64'd1 << b[4:0]));
            4'd13: return sext32({32'd0, a[31:0]} >> b[4:0]);
            4'd14: return sext32(64'(longint'(int'(a[31:0])) >>> b[4:0]));
            default: return 64'd0;
        endcase
    endfunction

    // One cycle: drive at negedge, check handshake against the model, predict the next edge.
    task automatic step(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] o0,
                        input logic [5:0] t0, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] o1,
                        input logic [5:0] t1, input logic rr);
        int w;
        bit can;
        @(negedge clk);
        req_valid = v; rs1[0] = a0; rs2[0] = b0; op[0] = o0; tag[0] = t0;
        rs1[1] = a1; rs2[1] = b1; op[1] = o1; tag[1] = t1; res_ready = rr;
        #1;
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        can = !m_valid || rr;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (w < 0 && v[(m_rr + k) % 2]) w = (m_rr + k) % 2;
        chk("req_ready", 64'(req_ready), (w >= 0 && can) ? 64'(1 << w) : 64'd0);
`ifdef ALU_ISSUE_ARB_PERF_EN
        if (m_valid && !rr) m_stall++;
        if (v == 2'b11 && can) m_conflict++;
        if (w >= 0 && can) m_grant[w]++;
`endif
        if (w >= 0 && can) begin
            q.push_back('{d: model_alu(w ? a1 : a0, w ? b1 : b0, w ? o1 : o0), t: w ? t1 : t0, s: w[0]});
            m_rr = (w + 1) % 2;
            m_valid = 1;
        end else if (rr) begin
            m_valid = 0;
        end
    endtask

    task automatic idle(input logic rr);
        step(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        #1;
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        q.delete();
        m_valid = 0;
        m_rr = 0;
`ifdef ALU_ISSUE_ARB_PERF_EN
        m_grant[0] = 0; m_grant[1] = 0; m_stall = 0; m_conflict = 0;
`endif
        #1;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", res_data, 64'd0);
        chk("rst_tag", 64'(res_tag), 64'd0);
        chk("rst_src", 64'(res_src), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every result handshake and checks stall stability.
    initial begin
        bit          prev_stall = 0;
        logic [63:0] prev_data = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (prev_stall && res_valid) chk("stall_hold", res_data, prev_data);
                if (res_valid && res_ready) begin
                    if (q.size() == 0) chk("unexpected_result", 64'(res_tag), 64'hx);
                    else begin
                        e = q.pop_front();
                        chk("res_data", res_data, e.d);
                        chk("res_tag", 64'(res_tag), 64'(e.t));
                        chk("res_src", 64'(res_src), 64'(e.s));
                    end
                end
            end
            prev_stall = res_valid && !res_ready && !rst;
            prev_data = res_data;
        end
    end

    initial begin
        do_reset();
        step(2'b01, 5, 7, 4'd0, 6'd3, 0, 0, 0, 0, 1'b1);
        idle(1'b1);
        chk("single_data", res_data, 64'd12);
        chk("single_tag", 64'(res_tag), 64'd3);
        idle(1'b1);
        for (int i = 0; i < 4; i++) step(2'b11, 10, 3, 4'd1, 6'd1, 64'hF0, 64'h0F, 4'd2, 6'd2, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(2'b01, 64'h7FFF_FFFF, 1, 4'd10, 6'd9, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b10, 0, 0, 0, 0, 64'd4, 64'd5, 4'd0, 6'd4, 1'b0);
        chk("addw_hold", res_data, 64'hFFFF_FFFF_8000_0000);
        step(2'b10, 0, 0, 0, 0, 64'd4, 64'd5, 4'd0, 6'd4, 1'b1);
        step(2'b01, 64'h8000_0000, 64'h24, 4'd14, 6'd5, 0, 0, 0, 0, 1'b1);
        step(2'b10, 0, 0, 0, 0, 64'd1, 64'h43, 4'd5, 6'd6, 1'b1);
        chk("sraw", res_data, 64'hFFFF_FFFF_F800_0000);
        step(2'b01, 64'd99, 64'd1, 4'd15, 6'd7, 0, 0, 0, 0, 1'b1);
        chk("sll", res_data, 64'd8);
        idle(1'b1);
        chk("unknown_op", res_data, 64'd0);
        chk("unknown_tag", 64'(res_tag), 64'd7);
        step(2'b10, 0, 0, 0, 0, 64'd1, 64'd2, 4'd0, 6'd8, 1'b0);
        idle(1'b0);
        do_reset();
        step(2'b11, 1, 1, 4'd0, 6'd1, 2, 2, 4'd0, 6'd2, 1'b1);
        chk("rst_first_grant", 64'(req_ready), 64'd1);
        for (int n = 0; n < 600; n++) begin
            logic [63:0] a0, b0, a1, b1;
            a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
            b0 = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
            b1 = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
            if (n == 300) do_reset();
            step(2'($urandom), a0, b0, 4'($urandom), 6'($urandom), a1, b1, 4'($urandom), 6'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("queue_empty", 64'(q.size()), 64'd0);
`ifdef ALU_ISSUE_ARB_PERF_EN
        @(negedge clk);
        #1;
        chk("perf_grant0", 64'(perf_grant[0]), 64'(m_grant[0]));
        chk("perf_grant1", 64'(perf_grant[1]), 64'(m_grant[1]));
        chk("perf_stall", 64'(perf_stall), 64'(m_stall));
        chk("perf_conflict", 64'(perf_conflict), 64'(m_conflict));
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
